// File: rtl/fifo_status_monitor.sv
// fifo_status_monitor: occupancy counters, sticky errors and threshold status for the MF/VC0/VC1/D0/D1 FIFOs
// Ports: clk, reset (async, active-high), umbrales_I {MF,VC0,VC1,D0,D1} thresholds,
//        active (freezes thresholds), push/pop strobes, FIFO_empty, FIFO_error (sticky),
//        almost_empty, almost_full, error_any. Vector bits: [4]=MF [3]=VC0 [2]=VC1 [1]=D0 [0]=D1.
module fifo_status_monitor #(
    parameter int MF_DEPTH = 4,
    parameter int VC_DEPTH = 16,
    parameter int D_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] umbrales_I,
    input  logic        active,
    input  logic [4:0]  push,
    input  logic [4:0]  pop,
    output logic [4:0]  FIFO_empty,
    output logic [4:0]  FIFO_error,
    output logic [4:0]  almost_empty,
    output logic [4:0]  almost_full,
    output logic        error_any
);
    logic [13:0] thr;
    always_ff @(posedge clk or posedge reset)
        if (reset) thr <= '0;
        else if (!active) thr <= umbrales_I;
    assign error_any = |FIFO_error;
    for (genvar i = 0; i < 5; i++) begin : g_fifo
        localparam int D   = i == 4 ? MF_DEPTH : i >= 2 ? VC_DEPTH : D_DEPTH;
        localparam int W   = $clog2(D + 1);
        localparam int TW  = (i == 2 || i == 3) ? 4 : 2;
        localparam int LSB = i == 4 ? 12 : i == 3 ? 8 : i == 2 ? 4 : 2 * i;
        // one bit wider than either operand so count + threshold never wraps
        localparam int SW  = (W > TW ? W : TW) + 1;
        logic [W-1:0]  cnt;
        logic          err;
        logic          empty;
        logic          full;
        logic [SW-1:0] c_x;
        logic [SW-1:0] t_x;
        assign empty = cnt == '0;
        assign full  = cnt == W'(D);
        assign c_x   = SW'(cnt);
        assign t_x   = SW'(thr[LSB +: TW]);
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                cnt <= '0;
                err <= 1'b0;
            end else begin
                err <= err | (pop[i] & empty) | (push[i] & ~pop[i] & full);
                // push+pop on empty: the pop underflows but the push still lands
                cnt <= push[i] & pop[i] ? (empty ? W'(1) : cnt)
                     : push[i] ? (full ? cnt : cnt + W'(1))
                     : pop[i] ? (empty ? cnt : cnt - W'(1))
                     : cnt;
            end
        assign FIFO_empty[i]   = empty;
        assign FIFO_error[i]   = err;
        assign almost_empty[i] = c_x <= t_x;
        assign almost_full[i]  = c_x + t_x >= SW'(D);
    end
endmodule

// File: tb/tb_fifo_status_monitor.sv
// tb_fifo_status_monitor: vector table, directed corner sequences and random stimulus against a count model
module tb_fifo_status_monitor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active = 1'b0;
    logic [13:0] umb = '0;
    logic [4:0]  push = '0;
    logic [4:0]  pop = '0;
    logic [4:0]  FIFO_empty, FIFO_error, almost_empty, almost_full;
    logic        error_any;

    fifo_status_monitor dut (
        .clk(clk), .reset(reset), .umbrales_I(umb), .active(active),
        .push(push), .pop(pop), .FIFO_empty(FIFO_empty), .FIFO_error(FIFO_error),
        .almost_empty(almost_empty), .almost_full(almost_full), .error_any(error_any)
    );

    always #5 clk = ~clk;

    localparam logic [13:0] U = 14'b01_0001_1100_11_11;
    int n_cmp = 0;
    int n_bad = 0;
    int depth [5] = '{4, 4, 16, 16, 4};
    int f_lsb [5] = '{0, 2, 4, 8, 12};
    int f_w   [5] = '{2, 2, 4, 4, 2};
    int m_cnt [5];
    bit [4:0]  m_err;
    bit [13:0] m_thr;

    typedef struct {
        logic [4:0]  pu, po;
        logic        act;
        logic [13:0] u;
        logic [4:0]  e_empty, e_err, e_ae, e_af;
    } vec_t;
    vec_t tbl [8];

    function automatic int fld(int i);
        return int'((m_thr >> f_lsb[i]) & ((14'd1 << f_w[i]) - 14'd1));
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [4:0] e, ae, af;
        for (int i = 0; i < 5; i++) begin
            e[i]  = m_cnt[i] == 0;
            ae[i] = m_cnt[i] <= fld(i);
            af[i] = m_cnt[i] + fld(i) >= depth[i];
        end
        chk({tag, ".empty"}, 16'(FIFO_empty), 16'(e));
        chk({tag, ".error"}, 16'(FIFO_error), 16'(m_err));
        chk({tag, ".almost_empty"}, 16'(almost_empty), 16'(ae));
        chk({tag, ".almost_full"}, 16'(almost_full), 16'(af));
        chk({tag, ".error_any"}, 16'(error_any), 16'(|m_err));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        m_err = '0;
        m_thr = '0;
    endtask

    task automatic cyc(input logic [4:0] pu, input logic [4:0] po, input logic act, input logic [13:0] u);
        push = pu;
        pop = po;
        active = act;
        umb = u;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            if (pu[i] && po[i]) begin
                if (m_cnt[i] == 0) begin
                    m_err[i] = 1'b1;
                    m_cnt[i] = 1;
                end
            end else if (po[i]) begin
                if (m_cnt[i] == 0) m_err[i] = 1'b1;
                else m_cnt[i]--;
            end else if (pu[i]) begin
                if (m_cnt[i] == depth[i]) m_err[i] = 1'b1;
                else m_cnt[i]++;
            end
        end
        if (!act) m_thr = u;
        #1;
        check_model("cyc");
    endtask

    // asserted mid-cycle with strobes still driven; outputs must clear before any edge
    task automatic do_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        check_model("reset");
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{5'b00000, 5'b00000, 1'b0, U,     5'b11111, 5'b00000, 5'b11111, 5'b00000};
        tbl[1] = '{5'b10000, 5'b10000, 1'b0, U,     5'b01111, 5'b10000, 5'b11111, 5'b00000};
        tbl[2] = '{5'b00011, 5'b00000, 1'b0, U,     5'b01100, 5'b10000, 5'b11111, 5'b00011};
        tbl[3] = '{5'b00000, 5'b00001, 1'b0, U,     5'b01101, 5'b10000, 5'b11111, 5'b00010};
        tbl[4] = '{5'b00000, 5'b00001, 1'b0, U,     5'b01101, 5'b10001, 5'b11111, 5'b00010};
        tbl[5] = '{5'b01000, 5'b00000, 1'b1, 14'd0, 5'b00101, 5'b10001, 5'b11111, 5'b00010};
        tbl[6] = '{5'b01000, 5'b00000, 1'b1, 14'd0, 5'b00101, 5'b10001, 5'b10111, 5'b00010};
        tbl[7] = '{5'b00000, 5'b00000, 1'b0, 14'd0, 5'b00101, 5'b10001, 5'b00101, 5'b00000};

        model_reset();
        #1 check_model("por");
        @(posedge clk);
        #1 reset = 1'b0;

        for (int k = 0; k < 8; k++) begin
            cyc(tbl[k].pu, tbl[k].po, tbl[k].act, tbl[k].u);
            chk($sformatf("tbl%0d.empty", k), 16'(FIFO_empty), 16'(tbl[k].e_empty));
            chk($sformatf("tbl%0d.error", k), 16'(FIFO_error), 16'(tbl[k].e_err));
            chk($sformatf("tbl%0d.ae", k), 16'(almost_empty), 16'(tbl[k].e_ae));
            chk($sformatf("tbl%0d.af", k), 16'(almost_full), 16'(tbl[k].e_af));
        end

        do_reset();
        cyc(5'b0, 5'b0, 1'b0, U);
        for (int k = 1; k <= 17; k++) begin
            cyc(5'b00100, 5'b0, 1'b0, U);
            chk($sformatf("vc1_fill%0d.af", k), 16'(almost_full[2]), 16'(k >= 4));
            chk($sformatf("vc1_fill%0d.err", k), 16'(FIFO_error[2]), 16'(k >= 17));
        end
        chk("vc1_fill.error_any", 16'(error_any), 16'd1);

        do_reset();
        cyc(5'b10000, 5'b10000, 1'b0, 14'd0);
        chk("mf_pp_empty.err", 16'(FIFO_error[4]), 16'd1);
        chk("mf_pp_empty.empty", 16'(FIFO_empty[4]), 16'd0);

        do_reset();
        cyc(5'b0, 5'b0, 1'b0, U);
        repeat (4) cyc(5'b00010, 5'b0, 1'b0, U);
        for (int k = 0; k < 3; k++) begin
            cyc(5'b00010, 5'b00010, 1'b0, U);
            chk("d0_full_pp.err", 16'(FIFO_error[1]), 16'd0);
            chk("d0_full_pp.af", 16'(almost_full[1]), 16'd1);
        end
        for (int k = 1; k <= 5; k++) begin
            cyc(5'b0, 5'b00010, 1'b0, U);
            chk($sformatf("d0_pop%0d.err", k), 16'(FIFO_error[1]), 16'(k == 5));
        end

        do_reset();
        cyc(5'b0, 5'b0, 1'b0, 14'b11 << 12);
        cyc(5'b10000, 5'b0, 1'b1, 14'd0);
        chk("freeze.ae", 16'(almost_empty[4]), 16'd1);
        cyc(5'b0, 5'b0, 1'b0, 14'd0);
        chk("unfreeze.ae", 16'(almost_empty[4]), 16'd0);

        cyc(5'b0, 5'b00001, 1'b0, 14'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(5'b0, 5'b0, k[0], 14'($urandom));
            chk("sticky.err", 16'(FIFO_error[0]), 16'd1);
        end
        do_reset();
        chk("sticky_cleared.err", 16'(FIFO_error), 16'd0);

        for (int k = 0; k < 3000; k++) begin
            logic [4:0] a, b;
            a = 5'($urandom | $urandom);
            b = 5'($urandom & $urandom);
            if ((k / 200) % 2 == 0) cyc(a, b, $urandom_range(0, 3) == 0, 14'($urandom));
            else cyc(b, a, $urandom_range(0, 3) == 0, 14'($urandom));
            if (k % 1000 == 999) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
